mux_rr_sched: RTL
=================

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 Parameter BURST, default 1, legal range 1..8: maximum consecutive transfers one requester may win while it keeps req asserted.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  10  per-requester request; bit i belongs to source i (0=a ... 9=j).
REQ-005 block_a..block_j  input  8 each  source data; block_a is index 0, block_j is index 9.
REQ-006 out_ready  input  1  downstream accept.
REQ-007 out_valid  output  1  block_out holds a valid word.
REQ-008 block_out  output  8  registered word from the granted source.
REQ-009 sel  output  4  registered index of the source held in block_out; values 0..9 only.
REQ-010 grant  output  10  registered one-hot capture pulse, high one cycle per captured word.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 Arbitration SHALL be round-robin: pick the first i with req[i]=1, scanning from ptr upward, wrapping 9->0.
REQ-013 IDLE with any req bit set at edge N: capture the winner's data into block_out, set sel=i and grant[i]=1, ptr=(i+1) mod 10, burst_cnt=0, enter HOLD. out_valid=1 in the cycle after edge N (latency 1).
REQ-014 IDLE with req=0: remain IDLE; block_out and sel hold their last values; grant=0.
REQ-015 HOLD with out_ready=0: block_out, sel and out_valid SHALL stay stable; grant=0; req is ignored.
REQ-016 HOLD with out_ready=1 (transfer completes at that edge): if burst_cnt<BURST-1 and req[sel]=1, recapture from the same source, burst_cnt+1, grant[sel]=1, ptr unchanged, stay HOLD.
REQ-017 Otherwise, on completion, re-arbitrate per REQ-012 from ptr over the current req. On a winner, capture it with burst_cnt=0, ptr=(i+1) mod 10 and a grant pulse, and stay HOLD (back-to-back, no bubble). With no winner, go IDLE and set out_valid=0 next cycle.
REQ-018 With BURST=1, REQ-016 SHALL never apply; every completion re-arbitrates.
REQ-019 ptr SHALL advance only on a new-source grant (REQ-013, REQ-017), never on burst continuation.
REQ-020 Data SHALL be sampled only at a capture edge; source data changes at other times do not affect block_out.
REQ-021 grant SHALL be at most one-hot. It SHALL be asserted exactly on the cycles following capture edges.
REQ-022 A requester that drops req while its word is held SHALL NOT affect the held word or out_valid.
REQ-023 Arbitration SHALL never select a source whose req bit is 0. sel SHALL never exceed 9.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, out_valid=0, block_out=8'h00, sel=0, grant=0, ptr=0, burst_cnt=0.
REQ-025 rst SHALL override every other input, including during HOLD; a held word is discarded without a transfer.
REQ-026 The first cycle after rst deasserts SHALL arbitrate normally from ptr=0.

Verification
REQ-027 Reset, then req=10'h001 with block_a=8'h11 and out_ready=1 held -> next cycle out_valid=1, block_out=8'h11, sel=0, grant=10'h001.
REQ-028 req=10'h3FF held, BURST=1, out_ready=1, data = index+8'hA0 -> sel sequence 0,1,...,9,0 on consecutive cycles with no bubbles; block_out=8'hA0+sel.
REQ-029 Word held from source 3, out_ready=0 for 5 cycles while block_d changes and req=10'h3FF -> block_out and sel unchanged and grant=0 for all 5 cycles; the next grant after out_ready=1 goes to source 4.
REQ-030 BURST=3, req=10'h081 held, out_ready=1 -> sel sequence 0,0,0,7,7,7,0 (after reset ptr=0).
REQ-031 ptr=9, req=10'h202 -> source 9 wins first, then wrap-around gives source 1.
REQ-032 rst=1 asserted while in HOLD with out_ready=0 -> next cycle out_valid=0, block_out=8'h00, sel=0. With req=10'h010 after release -> source 4 granted one cycle later.

Source files
------------

// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - ten-source round-robin word scheduler with per-source burst limit
module mux_rr_sched #(
    parameter int BURST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] req,
    input  logic [7:0] block_a,
    input  logic [7:0] block_b,
    input  logic [7:0] block_c,
    input  logic [7:0] block_d,
    input  logic [7:0] block_e,
    input  logic [7:0] block_f,
    input  logic [7:0] block_g,
    input  logic [7:0] block_h,
    input  logic [7:0] block_i,
    input  logic [7:0] block_j,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] block_out,
    output logic [3:0] sel,
    output logic [9:0] grant
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] ptr_q, ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [9:0] grant_q, grant_d;

    logic [7:0] src [10];
    logic       found;
    logic [3:0] win;
    logic [3:0] win_next;
    logic [4:0] idx;
    logic       take_new;

    assign src[0] = block_a;
    assign src[1] = block_b;
    assign src[2] = block_c;
    assign src[3] = block_d;
    assign src[4] = block_e;
    assign src[5] = block_f;
    assign src[6] = block_g;
    assign src[7] = block_h;
    assign src[8] = block_i;
    assign src[9] = block_j;

    // Round-robin pick: first requester at or after ptr, wrapping 9 -> 0
    always_comb begin
        found = 1'b0;
        win   = 4'd0;
        idx   = 5'd0;
        for (int k = 0; k < 10; k++) begin
            idx = 5'(ptr_q) + 5'(k);
            if (idx >= 5'd10) begin
                idx = idx - 5'd10;
            end
            if (!found && req[idx[3:0]]) begin
                found = 1'b1;
                win   = idx[3:0];
            end
        end
        win_next = (win == 4'd9) ? 4'd0 : win + 4'd1;
    end

    // Next-state: burst continuation takes priority, otherwise re-arbitrate on completion
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = '0;
        take_new = 1'b0;
        case (state_q)
            IDLE: begin
                take_new = found;
            end
            HOLD: begin
                if (out_ready) begin
                    if ((int'(cnt_q) + 1 < BURST) && req[sel_q]) begin
                        data_d  = src[sel_q];
                        cnt_d   = cnt_q + 3'd1;
                        grant_d = 10'd1 << sel_q;
                    end else if (found) begin
                        take_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (take_new) begin
            state_d = HOLD;
            data_d  = src[win];
            sel_d   = win;
            ptr_d   = win_next;
            cnt_d   = 3'd0;
            grant_d = 10'd1 << win;
        end
    end

    // State and registered outputs; reset discards any held word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            sel_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= 3'd0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign block_out = data_q;
    assign sel       = sel_q;
    assign grant     = grant_q;

endmodule
